// File: rtl/fetch_unit_pkg.sv
// Shared constants and payload types for the instruction fetch front end.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} entries ahead of decode.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  fetch_entry_t            push_data,
    input  logic                    pop,
    output fetch_entry_t            head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];
    assign count   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one-deep in-flight tracker, credit-based request
// throttling and a small FIFO that presents instructions to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        StallD,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = CW + 1;

    logic [31:0]  pc;
    logic         inflight_valid;
    logic [31:0]  inflight_pc;
    fetch_entry_t push_data;
    fetch_entry_t head;
    logic         push;
    logic         pop;
    logic         fifo_empty;
    logic         fifo_full_unused;
    logic [CW-1:0] fifo_count;
    logic [OW-1:0] occupancy;

    assign pop       = ValidD && !StallD;
    // A redirect or reset kills the response arriving this cycle.
    assign push      = inflight_valid && !redirect_valid && !rst;
    assign push_data = '{pc: inflight_pc, instr: imem_rdata};

    // Entries buffered plus the one in flight, after this cycle's pop.
    assign occupancy = OW'(fifo_count) + OW'(inflight_valid) - OW'(pop);
    assign imem_req  = !rst && !halt && !redirect_valid && (occupancy < OW'(DEPTH));
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            inflight_valid <= 1'b0;
            inflight_pc    <= '0;
        end else begin
            inflight_valid <= imem_req;
            inflight_pc    <= pc;
            if (redirect_valid) begin
                pc <= word_align(redirect_pc);
            end else if (imem_req) begin
                pc <= pc + 32'd4;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full_unused),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign ValidD   = !fifo_empty;
    assign InstrD   = ValidD ? head.instr : NOP_INSTR;
    assign PCD      = ValidD ? head.pc : 32'h0;
    assign PCPlus4D = PCD + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based model of the fetch pipeline.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] WPC   = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        StallD;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic [31:0] w_instr;
    logic [31:0] w_pcd;
    logic [31:0] w_p4;
    logic        w_valid;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .StallD(StallD), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    fetch_unit #(.RESET_PC(WPC), .DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .StallD(1'b0), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .halt(1'b0), .InstrD(w_instr), .PCD(w_pcd),
        .PCPlus4D(w_p4), .ValidD(w_valid)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    // Memory environment: the word returned depends only on the address.
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic        w_pend = 1'b0;
    logic [31:0] w_pend_addr = '0;

    // Reference model state.
    fetch_entry_t mq[$];
    logic         m_inf    = 1'b0;
    logic [31:0]  m_inf_pc = '0;
    logic [31:0]  m_pc     = RPC;

    logic [31:0] w_seen[$];
    logic [31:0] w_p4s[$];
    logic [31:0] w_ins[$];
    logic [31:0] wrap_exp[3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic rv,
                        input logic [31:0] rp, input logic h);
        logic        ev;
        logic        pop;
        logic        ereq;
        logic [31:0] epc;
        logic [31:0] ein;
        @(posedge clk);
        #1;
        rst            = r;
        StallD         = s;
        redirect_valid = rv;
        redirect_pc    = rp;
        halt           = h;
        imem_rdata     = pend ? mem_word(pend_addr) : $urandom;
        w_rdata        = w_pend ? mem_word(w_pend_addr) : $urandom;
        @(negedge clk);
        cyc++;

        ev   = (mq.size() > 0);
        epc  = ev ? mq[0].pc : 32'h0;
        ein  = ev ? mq[0].instr : NOP_INSTR;
        pop  = ev && !s;
        ereq = !r && !h && !rv &&
               ((mq.size() + (m_inf ? 1 : 0) - (pop ? 1 : 0)) < int'(DEPTH));

        check_eq("valid", 32'(ValidD), 32'(ev));
        check_eq("pcd", PCD, epc);
        check_eq("pcplus4", PCPlus4D, epc + 32'd4);
        check_eq("instr", InstrD, ein);
        check_eq("req", 32'(imem_req), 32'(ereq));
        if (ereq) check_eq("addr", imem_addr, m_pc);
        check_eq("push_full", 32'(dut.u_fifo.push & dut.u_fifo.full), 32'h0);

        if (r) begin
            mq.delete();
            m_inf = 1'b0;
            m_pc  = RPC;
        end else if (rv) begin
            mq.delete();
            m_inf = 1'b0;
            m_pc  = rp & 32'hFFFF_FFFC;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_inf) mq.push_back('{pc: m_inf_pc, instr: mem_word(m_inf_pc)});
            m_inf    = ereq;
            m_inf_pc = m_pc;
            if (ereq) m_pc = m_pc + 32'd4;
        end

        if (w_valid === 1'b1 && w_seen.size() < 3) begin
            w_seen.push_back(w_pcd);
            w_p4s.push_back(w_p4);
            w_ins.push_back(w_instr);
        end

        pend        = imem_req;
        pend_addr   = imem_addr;
        w_pend      = w_req;
        w_pend_addr = w_addr;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    int halt_hold = 0;

    initial begin
        rst = 1'b1; StallD = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        halt = 1'b0; imem_rdata = '0; w_rdata = '0;
        repeat (2) @(posedge clk);

        // Reset state.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("rst_req", 32'(imem_req), 32'h0);
        check_eq("rst_valid", 32'(ValidD), 32'h0);
        check_eq("rst_instr", InstrD, 32'h0000_0013);
        check_eq("rst_pcd", PCD, 32'h0);
        check_eq("rst_pcp4", PCPlus4D, 32'h4);

        // Streaming from reset.
        run(1); check_eq("s_addr0", imem_addr, 32'h0); check_eq("s_v0", 32'(ValidD), 32'h0);
        run(1); check_eq("s_addr1", imem_addr, 32'h4); check_eq("s_v1", 32'(ValidD), 32'h0);
        run(1); check_eq("s_addr2", imem_addr, 32'h8); check_eq("s_pcd0", PCD, 32'h0);
                check_eq("s_p4_0", PCPlus4D, 32'h4);
        run(1); check_eq("s_pcd1", PCD, 32'h4); check_eq("s_p4_1", PCPlus4D, 32'h8);

        // Decode stall while 0x8 is presented.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            check_eq("stall_pcd", PCD, 32'h8);
            check_eq("stall_p4", PCPlus4D, 32'hC);
            check_eq("stall_req", 32'(imem_req), 32'h0);
        end
        run(1); check_eq("rel_pcd", PCD, 32'h8); check_eq("rel_addr", imem_addr, 32'h10);

        // Redirect to 0x100 while 0x10 is in flight.
        step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
        check_eq("redir_pcd", PCD, 32'hC); check_eq("redir_req", 32'(imem_req), 32'h0);
        run(1); check_eq("redir_v", 32'(ValidD), 32'h0); check_eq("redir_addr", imem_addr, 32'h100);
        run(1); check_eq("redir_v2", 32'(ValidD), 32'h0);
        run(1); check_eq("redir_pcd2", PCD, 32'h100);

        // Halt right after the request to 0x20.
        step(1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
        run(1); check_eq("h_addr", imem_addr, 32'h20);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); check_eq("h_req0", 32'(imem_req), 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); check_eq("h_pcd", PCD, 32'h20);
                check_eq("h_req1", 32'(imem_req), 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); check_eq("h_req2", 32'(imem_req), 32'h0);
        run(1); check_eq("h_resume", imem_addr, 32'h24); check_eq("h_rreq", 32'(imem_req), 32'h1);

        // Misaligned redirect target.
        step(1'b0, 1'b0, 1'b1, 32'h203, 1'b0);
        run(1); check_eq("mis_addr", imem_addr, 32'h200);
        run(3);

        // Reset mid-stream.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        run(1); check_eq("mr_v", 32'(ValidD), 32'h0); check_eq("mr_addr", imem_addr, RPC);
                check_eq("mr_req", 32'(imem_req), 32'h1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        s;
            logic        rv;
            logic        h;
            logic [31:0] rp;
            r  = ($urandom_range(199) == 0);
            s  = ($urandom_range(99) < 30);
            rv = ($urandom_range(99) < 5);
            rp = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            if (halt_hold > 0) begin
                h = 1'b1;
                halt_hold--;
            end else begin
                h = 1'b0;
                if ($urandom_range(99) < 4) halt_hold = int'($urandom_range(6, 1));
            end
            step(r, s, rv, rp, h);
        end

        // Address wrap on the second instance.
        check_eq("wrap_n", 32'(w_seen.size()), 32'd3);
        for (int i = 0; i < 3 && i < w_seen.size(); i++) begin
            check_eq("wrap_pcd", w_seen[i], wrap_exp[i]);
            check_eq("wrap_instr", w_ins[i], mem_word(wrap_exp[i]));
        end
        if (w_p4s.size() > 1) check_eq("wrap_p4", w_p4s[1], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
